demux10_dispatch: RTL and testbench
===================================

# demux10_dispatch

- Registered 1-to-10 steering stage: the write-side counterpart of the 10-way select mux.
- Accepts one `WIDTH`-bit word per cycle with a 4-bit destination code and delivers it into one of ten one-entry output lanes.
- Each lane has its own valid/ready handshake.
- Used where a single producer (issue or writeback) fans out to per-lane consumers of the four-issue pipeline.

## Interface

Parameters:

- `WIDTH`, default 8: data width of the input word and of every lane.

Ports:

- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `in_valid`, input, 1: input word present.
- `in_ready`, output, 1: input word accepted this cycle when `in_valid` is also high.
- `in_sel`, input, 4: destination lane code.
- `in_data`, input, `WIDTH`: input word.
- `out_valid`, output, 10: bit i = lane i holds a word.
- `out_ready`, input, 10: bit i = lane i consumer takes the word this cycle.
- `y0` … `y9`, output, `WIDTH` each: lane data.
- `drop_cnt`, output, 8: saturating count of words dropped for an illegal `in_sel`.

## Operation

- Accept = `in_valid & in_ready` at a rising edge with `reset_n` high.
- Lane i is "free" when `!out_valid[i] | out_ready[i]`; a full lane being drained in the same cycle counts as free.
- Legal codes:
  - `in_sel` 0–9: `in_ready` = lane `in_sel` is free.
  - On accept: `out_valid[in_sel]` <= 1 and `y<in_sel>` <= `in_data`.
- Illegal codes:
  - `in_sel` 10–15: `in_ready` = 1. The word is accepted and discarded; no lane changes.
  - `drop_cnt` increments by 1 and saturates at 255, with no wrap.
  - Codes 10–14 are always illegal; code 15 is illegal unless the broadcast feature is compiled in (see Configuration).
- Lane update priority, each cycle:
  - Reset first.
  - Then a write from an accepted input; this wins over a simultaneous drain, so `out_valid` stays 1 with the new data.
  - Then a drain (`out_valid[i] & out_ready[i]`), which clears `out_valid[i]`.
- `y<i>` changes only on a write. It holds its last value when not valid and is stable while `out_valid[i] & !out_ready[i]`.
- Lanes are independent; draining lane j never affects lane i.
- `in_ready` is combinational from `in_sel`, `out_valid` and `out_ready`. `out_valid`, `y<i>` and `drop_cnt` are registered.

## Timing

- Reset values: `out_valid` = 0, `y0`–`y9` = 0, `drop_cnt` = 0.
- `in_ready` = 0 whenever `reset_n` is low.
- Reset mid-operation discards all lane contents; a word presented during that cycle is not accepted.
- Latency: a word accepted at edge N is visible on `y<sel>` with `out_valid[sel]` = 1 after edge N; consumer may take it at edge N+1.
- Throughput: one word per cycle into a lane whose consumer holds `out_ready` high continuously. No bubbles.
- Back-pressure: lane full and `out_ready[i]` low gives `in_ready` low for `in_sel` = i; other destinations are still accepted.
- Inputs `in_sel`/`in_data` need only be stable while `in_valid` is high and not yet accepted. There is no combinational path from `in_data` to any output.

## Configuration

- `DEMUX10_BROADCAST_EN` defined:
  - `in_sel` = 15 is a broadcast. `in_ready` = all ten lanes free.
  - On accept, every lane is written with `in_data` and every `out_valid` bit is set. `drop_cnt` is unchanged.
- `DEMUX10_BROADCAST_EN` undefined:
  - `in_sel` = 15 behaves as any other illegal code: accepted, dropped, `drop_cnt` increments.
- Codes 10–14 are illegal in both builds.

## Test plan

- Reset, then hold `reset_n` low for 2 cycles with `in_valid`=1 and `in_sel`=3 → `out_valid`=0, `in_ready`=0, `drop_cnt`=0, `y3`=0.
- Write 0xA5 to lane 3 with `out_ready`=0, then 0x5A to lane 3 → first word accepted and `out_valid[3]`=1, `y3`=0xA5. Second word stalls (`in_ready`=0) until `out_ready[3]`=1, then `y3`=0x5A one cycle later.
- Stream 8 words 0x10..0x17 to lane 9 with `out_ready[9]` held high → accepted on 8 consecutive edges; consumer sees 0x10..0x17 in order, no gaps.
- With lane 0 full and stalled, send 0x33 to lane 1 → accepted immediately; lane 0 data and valid unchanged.
- Send 300 words with `in_sel`=12 → all accepted, no `out_valid` bit set, `drop_cnt`=255.
- `in_sel`=15 with 0xC3:
  - With `DEMUX10_BROADCAST_EN`, all lanes empty → `out_valid`=0x3FF, all `y<i>`=0xC3.
  - With `DEMUX10_BROADCAST_EN`, lane 4 full and stalled → `in_ready`=0.
  - Without the macro → dropped, `drop_cnt` +1.

Source files
------------

// File: rtl/demux10_dispatch.sv
// demux10_dispatch: registered 1-to-10 steering stage with per-lane handshakes.
// Optional feature macro: DEMUX10_BROADCAST_EN (in_sel 15 writes all lanes).
module demux10_dispatch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [9:0]       out_valid,
    input  logic [9:0]       out_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [WIDTH-1:0] y8,
    output logic [WIDTH-1:0] y9,
    output logic [7:0]       drop_cnt
);

    logic [WIDTH-1:0] r_data [10];
    logic [9:0]       r_valid;
    logic [7:0]       r_drop;

    logic [9:0]       w_free;
    logic             w_legal;
    logic             w_bcast;
    logic             w_sel_free;
    logic             w_acc;
    logic             w_drop;
    logic [9:0]       w_wr;

    // A lane is free when empty or being drained this cycle.
    always_comb begin
        w_free = ~r_valid | out_ready;
    end

    // Classify the destination code and derive the input handshake.
    always_comb begin
        w_legal    = (in_sel <= 4'd9);
`ifdef DEMUX10_BROADCAST_EN
        w_bcast    = (in_sel == 4'd15);
`else
        w_bcast    = 1'b0;
`endif
        w_sel_free = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (in_sel == 4'(i)) begin
                w_sel_free = w_free[i];
            end
        end
        if (!reset_n) begin
            in_ready = 1'b0;
        end else if (w_legal) begin
            in_ready = w_sel_free;
        end else if (w_bcast) begin
            in_ready = &w_free;
        end else begin
            in_ready = 1'b1;
        end
        w_acc  = in_valid & in_ready;
        w_drop = w_acc & ~w_legal & ~w_bcast;
    end

    // Per-lane write strobes; broadcast hits every lane.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < 10; i++) begin
            w_wr[i] = w_acc & ((w_legal & (in_sel == 4'(i))) | w_bcast);
        end
    end

    // Lane state: write wins over drain, drain clears valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int i = 0; i < 10; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (w_wr[i]) begin
                    r_valid[i] <= 1'b1;
                    r_data[i]  <= in_data;
                end else if (out_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Saturating count of words discarded for an illegal code.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
        end
    end

    assign out_valid = r_valid;
    assign drop_cnt  = r_drop;
    assign y0 = r_data[0];
    assign y1 = r_data[1];
    assign y2 = r_data[2];
    assign y3 = r_data[3];
    assign y4 = r_data[4];
    assign y5 = r_data[5];
    assign y6 = r_data[6];
    assign y7 = r_data[7];
    assign y8 = r_data[8];
    assign y9 = r_data[9];

endmodule

// File: tb/tb_demux10_dispatch.sv
// tb_demux10_dispatch: vector table plus per-lane scoreboard queues.
// Broadcast checks are compiled in when DEMUX10_BROADCAST_EN is defined.
module tb_demux10_dispatch;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_sel;
    logic [7:0] in_data;
    logic [9:0] out_valid;
    logic [9:0] out_ready;
    logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7, y8, y9;
    logic [7:0] drop_cnt;
    logic [7:0] y [10];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q [10][$];
    int         m_drop = 0;

    typedef struct {
        logic       v;
        logic [3:0] sel;
        logic [7:0] data;
        logic [9:0] rdy;
        logic       exp_rdy;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    assign y[0] = y0; assign y[1] = y1; assign y[2] = y2;
    assign y[3] = y3; assign y[4] = y4; assign y[5] = y5;
    assign y[6] = y6; assign y[7] = y7; assign y[8] = y8;
    assign y[9] = y9;

    demux10_dispatch #(.WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .y5(y5), .y6(y6), .y7(y7), .y8(y8), .y9(y9),
        .drop_cnt(drop_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] m_valid();
        logic [9:0] m;
        for (int i = 0; i < 10; i++) m[i] = (q[i].size() != 0);
        return m;
    endfunction

    function automatic logic m_ready(input logic [3:0] sel,
                                     input logic [9:0] rdy);
        logic [9:0] fr;
        fr = ~m_valid() | rdy;
        if (sel <= 4'd9) return fr[sel];
`ifdef DEMUX10_BROADCAST_EN
        if (sel == 4'd15) return &fr;
`endif
        return 1'b1;
    endfunction

    // One clock: drive at negedge, check state, update the model.
    task automatic cycle(input logic v, input logic [3:0] sel,
                         input logic [7:0] data, input logic [9:0] rdy);
        logic er;
        @(negedge clk);
        reset_n   = 1'b1;
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = rdy;
        #1;
        er = m_ready(sel, rdy);
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(m_valid()));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        for (int i = 0; i < 10; i++) begin
            if (q[i].size() != 0) begin
                chk($sformatf("y%0d", i), 32'(y[i]), 32'(q[i][0]));
                if (rdy[i]) void'(q[i].pop_front());
            end
        end
        if (v && er) begin
            if (sel <= 4'd9) begin
                q[sel].push_back(data);
`ifdef DEMUX10_BROADCAST_EN
            end else if (sel == 4'd15) begin
                for (int i = 0; i < 10; i++) q[i].push_back(data);
`endif
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset_n   = 1'b0;
            in_valid  = 1'b1;
            in_sel    = 4'd3;
            in_data   = 8'hA5;
            out_ready = '0;
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
        end
        for (int i = 0; i < 10; i++) q[i].delete();
        m_drop = 0;
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_y3", 32'(y3), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;

        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 10'h000, 1'b1};
        vecs[1]  = '{1'b1, 4'd3,  8'h5A, 10'h000, 1'b0};
        vecs[2]  = '{1'b1, 4'd3,  8'h5A, 10'h000, 1'b0};
        vecs[3]  = '{1'b1, 4'd3,  8'h5A, 10'h008, 1'b1};
        vecs[4]  = '{1'b0, 4'd3,  8'h00, 10'h000, 1'b0};
        vecs[5]  = '{1'b1, 4'd0,  8'h77, 10'h000, 1'b1};
        vecs[6]  = '{1'b1, 4'd0,  8'h78, 10'h000, 1'b0};
        vecs[7]  = '{1'b1, 4'd1,  8'h33, 10'h000, 1'b1};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 10'h000, 1'b0};
        vecs[9]  = '{1'b1, 4'd10, 8'hEE, 10'h000, 1'b1};
        vecs[10] = '{1'b1, 4'd14, 8'hEF, 10'h000, 1'b1};
        vecs[11] = '{1'b0, 4'd0,  8'h00, 10'h3FF, 1'b1};

        do_reset(2);

        for (int k = 0; k < 12; k++) begin
            cycle(vecs[k].v, vecs[k].sel, vecs[k].data, vecs[k].rdy);
            chk($sformatf("vec%0d_ready", k), 32'(in_ready),
                32'(vecs[k].exp_rdy));
        end
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("after_vec_drop", 32'(drop_cnt), 32'd2);
        chk("after_vec_empty", 32'(out_valid), 32'd0);

        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 4'd9, 8'(8'h10 + k), 10'h200);
            chk($sformatf("stream%0d_ready", k), 32'(in_ready), 32'd1);
        end
        cycle(1'b0, 4'd0, 8'h00, 10'h200);
        chk("stream_last", 32'(y9), 32'h17);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);

`ifdef DEMUX10_BROADCAST_EN
        cycle(1'b1, 4'd15, 8'hC3, 10'h000);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("bcast_valid", 32'(out_valid), 32'h3FF);
        chk("bcast_y0", 32'(y0), 32'hC3);
        chk("bcast_y9", 32'(y9), 32'hC3);
        cycle(1'b1, 4'd15, 8'h3C, 10'h3EF);
        chk("bcast_stall", 32'(in_ready), 32'd0);
        cycle(1'b0, 4'd0, 8'h00, 10'h3FF);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("bcast_drop", 32'(drop_cnt), 32'd2);
`else
        cycle(1'b1, 4'd15, 8'hC3, 10'h000);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("sel15_drop", 32'(drop_cnt), 32'd3);
        chk("sel15_novalid", 32'(out_valid), 32'd0);
`endif

        for (int k = 0; k < 300; k++) begin
            cycle(1'b1, 4'd12, 8'(k), 10'h000);
        end
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_novalid", 32'(out_valid), 32'd0);

        cycle(1'b1, 4'd2, 8'h99, 10'h000);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);
        chk("pre_rst_valid", 32'(out_valid), 32'h004);
        do_reset(1);
        chk("midrst_y2", 32'(y2), 32'd0);
        cycle(1'b0, 4'd0, 8'h00, 10'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
